fifo_ctrl: RTL

Single-clock FIFO controller that drives the 16-bit x 128 dual-port sram as its storage array.
- Owns write/read pointers, occupancy count and full/empty/almost flags.
- Converts upstream valid/ready pushes into sram writes.
- Presents sram read data downstream as a first-word-fall-through valid/ready stream, hiding the sram's 1-cycle read latency.
- Sits between the 2D FIR line-buffer producer and its consumer; sram clk_wr and clk_rd are both tied to clk at the parent.

---
 rtl/fifo_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a 1-cycle-latency dual-port sram.
// Owns pointers, occupancy and threshold flags, and hides the sram read latency downstream.
module fifo_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int AFULL_TH  = 120,
  parameter int AEMPTY_TH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_wr_ptr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_ptr,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic [ADDR_W:0]   mem_cnt_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              out_valid_nxt;
  logic              push;

  // rst_n gates the handshakes so nothing reaches the sram while reset is held
  always_comb begin
    in_ready      = rst_n && !flush && (mem_cnt < DEPTH_C);
    push          = in_valid && in_ready;
    sram_wr_en    = push;
    sram_wr_ptr   = wr_ptr;
    sram_din      = in_data;
    sram_rd_en    = rst_n && !flush && (mem_cnt != '0) && (!out_valid || out_ready);
    sram_rd_ptr   = rd_ptr;
    mem_cnt_nxt   = mem_cnt;
    out_valid_nxt = out_valid;
    if (flush) begin
      mem_cnt_nxt   = '0;
      out_valid_nxt = 1'b0;
    end else begin
      case ({push, sram_rd_en})
        2'b10:   mem_cnt_nxt = mem_cnt + (ADDR_W+1)'(1);
        2'b01:   mem_cnt_nxt = mem_cnt - (ADDR_W+1)'(1);
        default: mem_cnt_nxt = mem_cnt;
      endcase
      if (sram_rd_en)
        out_valid_nxt = 1'b1;
      else if (out_valid && out_ready)
        out_valid_nxt = 1'b0;
    end
    count_nxt = mem_cnt_nxt + {{ADDR_W{1'b0}}, out_valid_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mem_cnt      <= '0;
      out_valid    <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + ADDR_W'(1);
        if (sram_rd_en)
          rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      mem_cnt      <= mem_cnt_nxt;
      out_valid    <= out_valid_nxt;
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
    end
  end

  // the sram holds data_out while no read issues, so the head word is stable under backpressure
  assign out_data = sram_dout;
  assign count    = mem_cnt + {{ADDR_W{1'b0}}, out_valid};

endmodule
